// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store:
// alternating priority, one registered request in flight, ack-or-timeout completion.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            f_req,
   input  logic [AW-1:0]   f_addr,
   output logic            f_gnt,
   output logic            f_done,
   output logic [DW-1:0]   f_rdata,
   input  logic            d_req,
   input  logic [AW-1:0]   d_addr,
   input  logic            d_we,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_bmask,
   output logic            d_gnt,
   output logic            d_done,
   output logic [DW-1:0]   d_rdata,
   output logic            err,
   output logic            stall,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_bmask,
   input  logic            mem_ack,
   input  logic [DW-1:0]   mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D} state_t;
   typedef enum logic {LAST_F, LAST_D} last_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   last_t      last_grant;
   logic [7:0] cnt;
   logic       f_win;
   logic       d_win;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      f_win = 1'b0;
      d_win = 1'b0;
      if (state == IDLE) begin
         // On a tie the requester that did not win last time goes first.
         if (f_req && (!d_req || last_grant == LAST_D)) f_win = 1'b1;
         else if (d_req)                                d_win = 1'b1;
      end
   end

   assign f_gnt = f_win;
   assign d_gnt = d_win;
   assign stall = (f_req & ~f_done) | (d_req & ~d_done);

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= LAST_F;
         cnt        <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_bmask  <= '0;
         f_done     <= 1'b0;
         d_done     <= 1'b0;
         err        <= 1'b0;
         f_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         f_done <= 1'b0;
         d_done <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               if (f_win) begin
                  state      <= BUSY_F;
                  last_grant <= LAST_F;
                  cnt        <= '0;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= f_addr;
                  mem_wdata  <= '0;
                  mem_bmask  <= '1;
               end else if (d_win) begin
                  state      <= BUSY_D;
                  last_grant <= LAST_D;
                  cnt        <= '0;
                  mem_req    <= 1'b1;
                  mem_we     <= d_we;
                  mem_addr   <= d_addr;
                  mem_wdata  <= d_wdata;
                  mem_bmask  <= d_we ? d_bmask : '1;
               end
            end
            BUSY_F, BUSY_D: begin
               // An ack in the last allowed cycle still counts as a normal completion.
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  if (state == BUSY_F) begin
                     f_done  <= 1'b1;
                     f_rdata <= mem_rdata;
                  end else begin
                     d_done  <= 1'b1;
                     d_rdata <= mem_we ? '0 : mem_rdata;
                  end
               end else if (cnt == CNT_LAST) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  err     <= 1'b1;
                  if (state == BUSY_F) begin
                     f_done  <= 1'b1;
                     f_rdata <= '0;
                  end else begin
                     d_done  <= 1'b1;
                     d_rdata <= '0;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the instruction-fetch path and the load/store path of the RV32I core.
- Accepts one request at a time, drives a registered memory request, and waits for a variable-latency acknowledge.
- Returns completion and read data to the winning requester, and produces the core stall signal.
- Sits between the fetch stage / LSU (driven by wr_en, bmask, ld_sel decode) and the memory model; byte extraction for ld_sel stays in the LSU.

Parameters:
- AW, 32, address width.
- DW, 32, data width; bmask width is DW/8.
- TIMEOUT, 16, maximum cycles in a BUSY state without mem_ack before abort; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request; held with f_addr until f_gnt.
- f_addr  in  AW  fetch address (word aligned).
- f_gnt  out  1  fetch accepted (combinational, 1-cycle pulse).
- f_done  out  1  fetch complete (registered, 1-cycle pulse).
- f_rdata  out  DW  fetched instruction, valid while f_done.
- d_req  in  1  data request; held with d_addr, d_we, d_wdata, d_bmask until d_gnt.
- d_addr  in  AW  data address.
- d_we  in  1  1 = store, 0 = load.
- d_wdata  in  DW  store data.
- d_bmask  in  DW/8  store byte enables.
- d_gnt  out  1  data accepted (combinational, 1-cycle pulse).
- d_done  out  1  data complete (registered, 1-cycle pulse).
- d_rdata  out  DW  load data, valid while d_done.
- err  out  1  asserted with f_done or d_done when the transaction timed out.
- stall  out  1  (f_req & ~f_done) | (d_req & ~d_done).
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  AW  registered.
- mem_wdata  out  DW  registered.
- mem_bmask  out  DW/8  registered; all ones for fetch/load.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset (async, any state): FSM to IDLE. mem_req, mem_we, f_done, d_done and err = 0. All data/address outputs = 0. Timeout counter = 0. last_grant = FETCH. An in-flight transaction is dropped silently.
- FSM states: IDLE, BUSY_F, BUSY_D.
- IDLE grant rules:
  - Only f_req: f_gnt = 1, go to BUSY_F.
  - Only d_req: d_gnt = 1, go to BUSY_D.
  - Both: grant the requester not in last_grant. After reset this means data first. Update last_grant.
- On the grant edge: latch address, we, wdata and bmask into the mem_* registers and set mem_req = 1. A fetch forces we = 0 and bmask = all ones.
- BUSY: mem_req and all mem_* outputs stay stable until mem_ack.
  - On mem_ack: register mem_rdata into f_rdata or d_rdata, pulse the matching done in the next cycle, clear mem_req, return to IDLE.
  - A store also gets d_done; d_rdata is then 0.
- Latency: grant at cycle 0, mem_req high at cycle 1, mem_ack at cycle k (k >= 1), done at cycle k+1, next grant possible at cycle k+1.
- mem_ack on the same cycle mem_req first rises is legal (k = 1).
- Timeout: counter clears on entering BUSY and increments each BUSY cycle without mem_ack. When the counter reaches TIMEOUT-1 with no ack:
  - abort, clear mem_req, return to IDLE;
  - next cycle pulse done with err = 1 and rdata = 0.
  - mem_ack arriving in the abort cycle takes precedence (normal completion, err = 0).
- mem_ack while in IDLE is ignored.
- f_rdata and d_rdata hold their value between done pulses.
- gnt is never asserted outside IDLE. A requester dropping req before gnt causes no transaction.

Test Plan:
- Only f_req, f_addr=0x0000_0010, mem_ack 3 cycles after mem_req with rdata=0x0000_0013 -> f_gnt at cycle 0; mem_addr=0x10, mem_we=0, mem_bmask=0xF; f_done and f_rdata=0x13 at cycle 4; stall=1 at cycles 0-3, then 0.
- f_req and d_req together after reset, store d_addr=0x100, wdata=0xDEADBEEF, bmask=0x3 -> data granted first with mem_we=1, mem_bmask=0x3; fetch granted in the cycle d_done pulses; order then alternates D, F, D, F.
- Load with mem_ack in the first mem_req cycle, rdata=0x8000_00FF -> d_done at cycle 2 with d_rdata=0x8000_00FF, err=0.
- TIMEOUT=4, mem_ack never asserted -> mem_req drops after 4 cycles, then d_done=1 with err=1 and d_rdata=0; the next request is accepted normally.
- rst_n pulled low mid-BUSY_D -> mem_req=0 immediately with no done pulse. After release, a pending f_req is granted in the first cycle.
- mem_ack pulsed in IDLE with no request -> no done, no state change.
